// File: rtl/if_id_pipeline_reg_if.sv
// IF->ID handshake bundle: fetch-side inputs, hazard controls and the registered
// view presented to decode.
interface if_id_pipeline_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  hit;
    logic                  stall;
    logic                  flush;
    logic [DATA_WIDTH-1:0] instruction_out;
    logic [DATA_WIDTH-1:0] next_pc_out;
    logic                  hit_out;
    logic                  valid_out;

    // Fetch/hazard side: drives the stage inputs and observes what decode sees.
    modport master (
        output next_pc, instruction, hit, stall, flush,
        input  instruction_out, next_pc_out, hit_out, valid_out
    );

    // The pipeline register itself.
    modport slave (
        input  next_pc, instruction, hit, stall, flush,
        output instruction_out, next_pc_out, hit_out, valid_out
    );
endinterface

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: captures fetch results once per clock, with stall (hold)
// and flush (bubble insert) for hazard handling. All outputs come straight from flops.
module if_id_pipeline_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    if_id_pipeline_reg_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0] next_pc;
        logic                  hit;
        logic                  valid;
    } stage_t;

    localparam stage_t BUBBLE = '{
        instruction: NOP_INSTR,
        next_pc:     '0,
        hit:         1'b0,
        valid:       1'b0
    };

    stage_t stage_q;
    stage_t fetched;

    // A miss is still captured for debug visibility, but flagged as a bubble.
    always_comb begin
        fetched.instruction = bus.instruction;
        fetched.next_pc     = bus.next_pc;
        fetched.hit         = bus.hit;
        fetched.valid       = bus.hit;
    end

    // Flush beats stall. Testing stall positively means an X on either control
    // falls through to a normal load, i.e. is treated as 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= BUBBLE;
        end else if (bus.flush) begin
            stage_q <= BUBBLE;
        end else if (bus.stall) begin
            stage_q <= stage_q;
        end else begin
            stage_q <= fetched;
        end
    end

    assign bus.instruction_out = stage_q.instruction;
    assign bus.next_pc_out     = stage_q.next_pc;
    assign bus.hit_out         = stage_q.hit;
    assign bus.valid_out       = stage_q.valid;
endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Self-checking bench for if_id_pipeline_reg: directed hazard cases plus a random
// stream with inputs churning between edges, checked against a reference model.
module tb_if_id_pipeline_reg;
    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clock;
    logic reset_n;

    if_id_pipeline_reg_if #(.DATA_WIDTH(DW)) bus ();

    if_id_pipeline_reg #(
        .DATA_WIDTH(DW),
        .NOP_INSTR (NOP)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // Reference: what decode should currently see.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        hit;
        logic        valid;
    } view_t;

    view_t exp_v;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"}, 64'(bus.instruction_out), 64'(exp_v.instr));
        check({tag, ".pc"},    64'(bus.next_pc_out),     64'(exp_v.pc));
        check({tag, ".hit"},   64'(bus.hit_out),         64'(exp_v.hit));
        check({tag, ".valid"}, 64'(bus.valid_out),       64'(exp_v.valid));
    endtask

    function automatic view_t bubble();
        view_t b;
        b.instr = NOP;
        b.pc    = '0;
        b.hit   = 1'b0;
        b.valid = 1'b0;
        return b;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input logic h, input logic st, input logic fl);
        bus.next_pc     = pc;
        bus.instruction = ins;
        bus.hit         = h;
        bus.stall       = st;
        bus.flush       = fl;
    endtask

    task automatic drive_garbage();
        drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One cycle: churn inputs twice, settle on the real values, confirm the
    // outputs held still all cycle, then check the capture just after the edge.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic h, input logic st, input logic fl);
        @(negedge clock);
        #2 drive_garbage();
        #8 drive_garbage();
        #5 drive(pc, ins, h, st, fl);
        #2 check_all({tag, ".hold"});
        @(posedge clock);
        #1;
        if (fl) begin
            exp_v = bubble();
        end else if (!st) begin
            exp_v.instr = ins;
            exp_v.pc    = pc;
            exp_v.hit   = h;
            exp_v.valid = h;
        end
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        exp_v = bubble();

        #5 check_all("rst_init");
        @(posedge clock);
        #1 check_all("rst_edge");
        #9 reset_n = 1'b1;

        // Normal flow
        step("normal", 32'h0000_0004, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
        check("normal_const", 64'(bus.instruction_out), 64'h2008_0005);

        // Asynchronous reset mid-cycle, held across edges with live inputs
        #9;
        drive(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        exp_v   = bubble();
        #1 check_all("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1 check_all("rst_held");
        end
        #9 reset_n = 1'b1;
        #1 check_all("rst_release");
        step("first_load", 32'h0000_0008, 32'h0000_0020, 1'b1, 1'b0, 1'b0);

        // Stall for three edges with fresh inputs, then resume
        step("stall_load", 32'h0000_000C, 32'h8C09_0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", $urandom, $urandom, 1'b1, 1'b1, 1'b0);
            check("stall_const", 64'(bus.instruction_out), 64'h8C09_0000);
        end
        step("unstall", 32'h0000_0010, 32'h0109_5020, 1'b1, 1'b0, 1'b0);

        // Flush alone, then flush with stall
        step("flush", 32'h0000_0014, 32'hAAAA_5555, 1'b1, 1'b0, 1'b1);
        step("reload", 32'h0000_0018, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
        step("flush_stall", 32'h0000_001C, 32'h3333_4444, 1'b1, 1'b1, 1'b1);
        check("flush_stall_valid", 64'(bus.valid_out), 64'h0);

        // Miss: captured but not valid
        step("miss", 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        check("miss_const", 64'(bus.instruction_out), 64'h1234_5678);

        // Random stream
        for (int n = 0; n < 300; n++) begin
            step("rand", $urandom, $urandom, 1'($urandom),
                 ($urandom_range(3) == 0), ($urandom_range(7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
